im_loader: RTL

IM_LOADER -- requirements
Module: im_loader

---
 rtl/im_pkg.sv | 7 +
 rtl/im_word_serializer.sv | 29 ++
 rtl/im_loader.sv | 77 +++++++
 3 files changed

// File: rtl/im_pkg.sv
// im_pkg: shared instruction-memory geometry and loader state encoding
package im_pkg;
  localparam int MEM_SIZE = 128;
  localparam int ADDR_W = 7;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/im_word_serializer.sv
// im_word_serializer: latches a 32-bit word and emits its bytes MSB first
module im_word_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_adv,
  input  logic [31:0] i_word,
  output logic [7:0]  o_byte,
  output logic [1:0]  o_idx,
  output logic        o_last_byte
);
  logic [31:0] r_word;
  logic [1:0]  r_idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_idx  <= '0;
    end else if (i_adv) begin
      r_idx  <= r_idx + 2'd1;
    end
  end
  // ~idx*8 selects bit 24 for offset 0 down to bit 0 for offset 3
  assign o_byte      = r_word[{~r_idx, 3'b000} +: 8];
  assign o_idx       = r_idx;
  assign o_last_byte = &r_idx;
endmodule

// File: rtl/im_loader.sv
// im_loader: accepts 32-bit words and writes them big-endian into byte memory
module im_loader #(
  parameter int MEM_SIZE = im_pkg::MEM_SIZE,
  parameter int ADDR_W   = im_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [5:0]        word_count
);
  import im_pkg::*;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_base;
  logic [5:0]        r_count;
  logic              r_last;
  logic              w_accept, w_write, w_restart, w_last_byte, w_finish;
  logic [7:0]        w_byte;
  logic [1:0]        w_idx;
  assign w_accept  = (r_state == S_LOAD) && in_valid;
  assign w_write   = (r_state == S_WRITE);
  assign w_restart = start && (r_state == S_IDLE || r_state == S_DONE);
  // the last word slot ends the session even without in_last, so the base never wraps
  assign w_finish  = r_last || (r_base == ADDR_W'(MEM_SIZE - BYTES_PER_WORD));
  im_word_serializer u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_adv       (w_write),
    .i_word      (in_word),
    .o_byte      (w_byte),
    .o_idx       (w_idx),
    .o_last_byte (w_last_byte)
  );
  always_comb begin
    w_next     = r_state;
    in_ready   = r_state == S_LOAD;
    busy       = r_state == S_LOAD || w_write;
    done       = r_state == S_DONE;
    mem_we     = w_write;
    mem_addr   = w_write ? r_base + ADDR_W'(w_idx) : '0;
    mem_wdata  = w_write ? w_byte : '0;
    word_count = r_count;
    case (r_state)
      S_IDLE, S_DONE: w_next = start ? S_LOAD : r_state;
      S_LOAD:         w_next = in_valid ? S_WRITE : S_LOAD;
      S_WRITE:        w_next = !w_last_byte ? S_WRITE : (w_finish ? S_DONE : S_LOAD);
      default:        w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_last <= in_last;
      if (w_restart) begin
        r_base  <= '0;
        r_count <= '0;
      end else if (w_write && w_last_byte) begin
        r_base  <= r_base + ADDR_W'(BYTES_PER_WORD);
        r_count <= r_count + 6'd1;
      end
    end
  end
endmodule
